// File: rtl/ram_arbiter.sv
// Shared block-RAM arbiter: multiplexes the 6502 core and NUM_CLIENTS
// peripheral masters onto one RAM port. The CPU is paused only at an
// instruction boundary (cpu_sync), and every client grant is followed by one
// address-restore cycle so the RAM output is re-registered from cpu_addr
// before the core resumes.
module ram_arbiter #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLIENTS = 2,
  parameter int RR_MODE     = 0,
  parameter int MAX_GRANT   = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             cpu_addr,
  input  logic [DATA_WIDTH-1:0]             cpu_wdata,
  input  logic                              cpu_we,
  input  logic                              cpu_sync,
  output logic                              cpu_ready,
  input  logic [NUM_CLIENTS-1:0]            client_req,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_wdata,
  input  logic [NUM_CLIENTS-1:0]            client_we,
  output logic [NUM_CLIENTS-1:0]            client_grant,
  output logic [NUM_CLIENTS-1:0]            client_rvalid,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_wdata,
  output logic                              ram_we
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W = (MAX_GRANT > 0) ? $clog2(MAX_GRANT + 1) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        win_q, win_d;     // client currently owning the RAM
  logic [IDX_W-1:0]        last_q, last_d;   // round-robin pointer (last winner)
  logic [CNT_W-1:0]        cnt_q, cnt_d;     // grant cycles already used
  logic                    cpu_ready_q;
  logic [NUM_CLIENTS-1:0]  grant_q, grant_d;
  logic [NUM_CLIENTS-1:0]  rvalid_q, rvalid_d;

  logic [ADDR_WIDTH-1:0]   c_addr  [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0]   c_wdata [NUM_CLIENTS];
  logic [IDX_W-1:0]        pick;
  logic                    budget_ok;

  // Unpack the flat client buses into per-client arrays.
  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign c_addr[gi]  = client_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign c_wdata[gi] = client_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Winner selection: round robin looks strictly after the last winner first,
  // then wraps to the lowest index; fixed priority is just the wrap pass.
  always_comb begin
    logic found;
    found = 1'b0;
    pick  = '0;
    if (RR_MODE != 0) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (!found && client_req[i] && (i > int'(last_q))) begin
          found = 1'b1;
          pick  = IDX_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!found && client_req[i]) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
  end

  // Another grant cycle is allowed while the used count stays under the cap.
  assign budget_ok = (MAX_GRANT == 0) || ((int'(cnt_q) + 1) < MAX_GRANT);

  // Next-state logic for the RUN / GRANT / RESTORE sequence.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if ((|client_req) && cpu_sync) begin
          state_d = ST_GRANT;
          win_d   = pick;
          cnt_d   = '0;
          if (RR_MODE != 0) last_d = pick;
        end
      end
      ST_GRANT: begin
        if (!client_req[win_q] || !budget_ok) begin
          state_d = ST_RESTORE;
        end else if (MAX_GRANT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESTORE: state_d = ST_RUN;
      default:    state_d = ST_RESTORE;
    endcase
  end

  // Registered outputs follow the next state so they line up with it.
  always_comb begin
    grant_d  = '0;
    if (state_d == ST_GRANT) grant_d = NUM_CLIENTS'(1) << win_d;
    rvalid_d = grant_q & ~client_we;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RESTORE;
      win_q       <= '0;
      last_q      <= IDX_W'(NUM_CLIENTS - 1);
      cnt_q       <= '0;
      cpu_ready_q <= 1'b0;
      grant_q     <= '0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      cpu_ready_q <= (state_d == ST_RUN);
      grant_q     <= grant_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // RAM port mux; writes are suppressed while reset is asserted so an
  // interrupted client write never lands.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    case (state_q)
      ST_RUN: ram_we = cpu_we;
      ST_GRANT: begin
        ram_addr  = c_addr[win_q];
        ram_wdata = c_wdata[win_q];
        ram_we    = client_we[win_q];
      end
      default: ram_we = 1'b0;
    endcase
    if (reset) ram_we = 1'b0;
  end

  assign cpu_ready     = cpu_ready_q;
  assign client_grant  = grant_q;
  assign client_rvalid = rvalid_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: three instances (fixed priority, round
// robin with a 2-cycle cap, fixed priority with a 4-cycle cap) share clock,
// reset and the CPU side; a small RAM model sits on the fixed-priority port.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_sync;

  // fixed priority, NUM_CLIENTS=2, unlimited grant
  logic [1:0]  fp_req, fp_we, fp_grant, fp_rvalid;
  logic [21:0] fp_addr;
  logic [15:0] fp_wdata;
  logic        fp_ready, fp_ram_we;
  logic [10:0] fp_ram_addr;
  logic [7:0]  fp_ram_wdata, fp_rdata;

  // round robin, NUM_CLIENTS=3, MAX_GRANT=2
  logic [2:0]  rr_req, rr_we, rr_grant, rr_rvalid;
  logic [32:0] rr_addr;
  logic [23:0] rr_wdata;
  logic        rr_ready, rr_ram_we;
  logic [10:0] rr_ram_addr;
  logic [7:0]  rr_ram_wdata;

  // fixed priority, NUM_CLIENTS=2, MAX_GRANT=4
  logic [1:0]  mg_req, mg_we, mg_grant, mg_rvalid;
  logic [21:0] mg_addr;
  logic [15:0] mg_wdata;
  logic        mg_ready, mg_ram_we;
  logic [10:0] mg_ram_addr;
  logic [7:0]  mg_ram_wdata;

  logic [7:0]  mem [0:2047];
  logic [7:0]  old_val;
  logic [2:0]  rr_exp [4];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .NUM_CLIENTS(2), .RR_MODE(0), .MAX_GRANT(0)) u_fp (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_sync(cpu_sync), .cpu_ready(fp_ready), .client_req(fp_req), .client_addr(fp_addr),
    .client_wdata(fp_wdata), .client_we(fp_we), .client_grant(fp_grant), .client_rvalid(fp_rvalid),
    .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata), .ram_we(fp_ram_we));

  ram_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .NUM_CLIENTS(3), .RR_MODE(1), .MAX_GRANT(2)) u_rr (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_sync(cpu_sync), .cpu_ready(rr_ready), .client_req(rr_req), .client_addr(rr_addr),
    .client_wdata(rr_wdata), .client_we(rr_we), .client_grant(rr_grant), .client_rvalid(rr_rvalid),
    .ram_addr(rr_ram_addr), .ram_wdata(rr_ram_wdata), .ram_we(rr_ram_we));

  ram_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .NUM_CLIENTS(2), .RR_MODE(0), .MAX_GRANT(4)) u_mg (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_sync(cpu_sync), .cpu_ready(mg_ready), .client_req(mg_req), .client_addr(mg_addr),
    .client_wdata(mg_wdata), .client_we(mg_we), .client_grant(mg_grant), .client_rvalid(mg_rvalid),
    .ram_addr(mg_ram_addr), .ram_wdata(mg_ram_wdata), .ram_we(mg_ram_we));

  // Single-port RAM model with registered read.
  always @(posedge clk) begin
    if (fp_ram_we) mem[fp_ram_addr] <= fp_ram_wdata;
    fp_rdata <= mem[fp_ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    reset = 1'b1; cpu_addr = 11'h123; cpu_wdata = 8'h77; cpu_we = 1'b1; cpu_sync = 1'b0;
    fp_req = '0; fp_we = '0; fp_addr = {11'h200, 11'h050}; fp_wdata = {8'hA5, 8'h11};
    rr_req = '0; rr_we = '0; rr_addr = {11'h3C0, 11'h3B0, 11'h3A0}; rr_wdata = '0;
    mg_req = '0; mg_we = '0; mg_addr = {11'h710, 11'h700}; mg_wdata = '0;

    // Reset held for 3 cycles: all registered outputs and ram_we low.
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_ready", 32'(fp_ready), 0);
      check("rst_grant", 32'(fp_grant), 0);
      check("rst_rvalid", 32'(fp_rvalid), 0);
      check("rst_ram_we", 32'(fp_ram_we), 0);
    end
    check("rst_rr_grant", 32'(rr_grant), 0);
    reset = 1'b0;
    #1;
    check("restore_ready", 32'(fp_ready), 0);
    check("restore_ram_we", 32'(fp_ram_we), 0);
    check("restore_addr", 32'(fp_ram_addr), 'h123);
    step();
    check("run_ready_fp", 32'(fp_ready), 1);
    check("run_ready_rr", 32'(rr_ready), 1);
    check("run_ready_mg", 32'(mg_ready), 1);
    check("run_cpu_we", 32'(fp_ram_we), 1);
    cpu_we = 1'b0;

    // Single client: request waits for sync, then write A5 and read it back.
    fp_req = 2'b10; fp_we = 2'b10;
    for (int c = 0; c < 5; c++) begin
      step();
      check("nosync_grant", 32'(fp_grant), 0);
      check("nosync_ready", 32'(fp_ready), 1);
    end
    cpu_sync = 1'b1;
    step();
    cpu_sync = 1'b0;
    #1;
    check("single_grant", 32'(fp_grant), 'b10);
    check("single_ready", 32'(fp_ready), 0);
    check("single_addr", 32'(fp_ram_addr), 'h200);
    check("single_wdata", 32'(fp_ram_wdata), 'hA5);
    check("single_we", 32'(fp_ram_we), 1);
    step();
    fp_we = 2'b00;
    #1;
    check("write_rvalid", 32'(fp_rvalid), 0);
    check("read_we", 32'(fp_ram_we), 0);
    step();
    check("read_rvalid", 32'(fp_rvalid), 'b10);
    check("read_data", 32'(fp_rdata), 'hA5);
    fp_req = 2'b00; cpu_we = 1'b1;
    step();
    check("drop_grant", 32'(fp_grant), 0);
    check("drop_ready", 32'(fp_ready), 0);
    check("drop_addr", 32'(fp_ram_addr), 'h123);
    check("drop_we", 32'(fp_ram_we), 0);
    check("drop_rvalid", 32'(fp_rvalid), 'b10);
    step();
    check("resume_ready", 32'(fp_ready), 1);
    check("resume_rvalid", 32'(fp_rvalid), 0);
    check("resume_we", 32'(fp_ram_we), 1);
    cpu_we = 1'b0;

    // Fixed priority: both request, client 0 wins; client 1 waits for next sync.
    fp_req = 2'b11; cpu_sync = 1'b1;
    step();
    cpu_sync = 1'b0;
    #1;
    check("fp_first", 32'(fp_grant), 'b01);
    check("fp_first_addr", 32'(fp_ram_addr), 'h050);
    fp_req = 2'b10;
    step();
    check("fp_restore_grant", 32'(fp_grant), 0);
    check("fp_restore_ready", 32'(fp_ready), 0);
    step();
    check("fp_run_ready", 32'(fp_ready), 1);
    check("fp_run_grant", 32'(fp_grant), 0);
    step();
    check("fp_wait_grant", 32'(fp_grant), 0);
    cpu_sync = 1'b1;
    step();
    cpu_sync = 1'b0;
    check("fp_second", 32'(fp_grant), 'b10);
    fp_req = 2'b00;
    step();
    step();
    check("fp_end_ready", 32'(fp_ready), 1);

    // Round robin with 3 clients all requesting, sync every 4 cycles.
    rr_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      cpu_sync = 1'b1;
      step();
      cpu_sync = 1'b0;
      #1;
      check("rr_grant_a", 32'(rr_grant), 32'(rr_exp[k]));
      step();
      check("rr_grant_b", 32'(rr_grant), 32'(rr_exp[k]));
      step();
      check("rr_restore", 32'(rr_grant), 0);
      check("rr_restore_ready", 32'(rr_ready), 0);
      step();
      check("rr_run_ready", 32'(rr_ready), 1);
    end
    rr_req = 3'b000;

    // Grant cap of 4 cycles with request held continuously.
    mg_req = 2'b01; cpu_sync = 1'b1;
    step();
    cpu_sync = 1'b0;
    #1;
    check("mg_grant_1", 32'(mg_grant), 'b01);
    for (int c = 0; c < 3; c++) begin
      step();
      check("mg_grant_n", 32'(mg_grant), 'b01);
    end
    step();
    check("mg_expire_grant", 32'(mg_grant), 0);
    check("mg_expire_ready", 32'(mg_ready), 0);
    step();
    check("mg_run_ready", 32'(mg_ready), 1);
    check("mg_run_grant", 32'(mg_grant), 0);
    step();
    check("mg_nosync_grant", 32'(mg_grant), 0);
    cpu_sync = 1'b1;
    step();
    cpu_sync = 1'b0;
    check("mg_regrant", 32'(mg_grant), 'b01);
    mg_req = 2'b00;
    step();
    step();
    check("mg_end_ready", 32'(mg_ready), 1);

    // Reset arrives in a write grant: the write must never reach the RAM.
    old_val = mem[11'h050];
    fp_req = 2'b01; fp_we = 2'b01; cpu_sync = 1'b1;
    step();
    cpu_sync = 1'b0;
    #1;
    check("rg_grant", 32'(fp_grant), 'b01);
    check("rg_we", 32'(fp_ram_we), 1);
    reset = 1'b1;
    #1;
    check("rg_we_in_reset", 32'(fp_ram_we), 0);
    step();
    check("rg_grant_after", 32'(fp_grant), 0);
    check("rg_we_after", 32'(fp_ram_we), 0);
    check("rg_ready_after", 32'(fp_ready), 0);
    reset = 1'b0; fp_req = 2'b00; fp_we = 2'b00;
    step();
    check("rg_mem", 32'(mem[11'h050]), 32'(old_val));
    step();
    check("rg_ready_back", 32'(fp_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Parametrised arbiter for the shared system block RAM. It multiplexes the 6502 core and NUM_CLIENTS peripheral masters (VGA fetch, UART program loader, future DMA/audio) onto one single-port-style RAM interface. It halts the CPU only at an instruction boundary (SYNC), grants one client at a time under fixed-priority or round-robin policy, and performs an explicit one-cycle address-restore before releasing the CPU, so the CPU never sees a stale read.

## Interface
Parameters:
- ADDR_WIDTH, 11, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- NUM_CLIENTS, 2, number of peripheral masters (1..8).
- RR_MODE, 0, 0 = fixed priority (client 0 highest), 1 = round robin.
- MAX_GRANT, 0, maximum consecutive cycles per grant; 0 = unlimited.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (25 MHz pixel clock domain).
- reset  in  1  synchronous, active-high.
- cpu_addr  in  ADDR_WIDTH  CPU address bus (combinatorial from core).
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_sync  in  1  CPU starting a new instruction.
- cpu_ready  out  1  CPU RDY; 0 pauses core.
- client_req  in  NUM_CLIENTS  per-client request, held until done.
- client_addr  in  NUM_CLIENTS*ADDR_WIDTH  packed, client i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- client_wdata  in  NUM_CLIENTS*DATA_WIDTH  packed likewise.
- client_we  in  NUM_CLIENTS  per-client write enable.
- client_grant  out  NUM_CLIENTS  one-hot grant.
- client_rvalid  out  NUM_CLIENTS  ram_rdata valid for client i this cycle.
- ram_addr  out  ADDR_WIDTH  drives both raddr and waddr of RAM.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_we  out  1  RAM write enable.

## Operation
- States: RUN, GRANT, RESTORE. Reset state RESTORE.
- RUN: cpu_ready=1, mux selects CPU, ram_we = cpu_we. If |client_req and cpu_sync: pick winner, register client_grant one-hot, cpu_ready<=0, go GRANT. Requests without cpu_sync wait.
- Winner: RR_MODE=0 lowest asserted index; RR_MODE=1 first asserted index strictly after last winner (modulo NUM_CLIENTS), pointer reset to NUM_CLIENTS-1 so client 0 wins first.
- GRANT: mux selects winner's addr/wdata; ram_we = client_we[winner]. Stay while client_req[winner]=1 and grant counter < MAX_GRANT (when MAX_GRANT≠0). Exit: clear client_grant, go RESTORE.
- RESTORE: cpu_ready=0, mux selects CPU, ram_we=0; exactly one cycle, then RUN. Guarantees RAM output registered from cpu_addr before core resumes.
- After each grant the CPU runs at least until its next cpu_sync, guaranteeing CPU progress; back-to-back client grants never occur without an intervening RUN cycle.
- client_rvalid[i] = registered (client_grant[i] & ~client_we[i]); asserted the cycle after each granted read address.
- Grant counter width clog2(MAX_GRANT+1); cleared on entry to GRANT.
- A client dropping req at MAX_GRANT expiry: release anyway; it re-arbitrates at the next sync.

## Timing
- Reset values: cpu_ready=0, client_grant=0, client_rvalid=0, ram_we=0, state RESTORE, RR pointer NUM_CLIENTS-1. cpu_ready=1 in the second cycle after reset deasserts.
- Reset mid-grant: grant drops in the cycle after reset is sampled; no RAM write in that cycle.
- Request-to-grant latency: 1 cycle after the first cycle with req & cpu_sync in RUN.
- Req drop to cpu_ready=1: 2 cycles (GRANT→RESTORE→RUN).
- Simultaneous requests resolved in the single arbitration cycle; losers stay pending.
- ram_addr/ram_we/ram_wdata are combinational from state and inputs; client_grant, cpu_ready, client_rvalid are registered.

## Test plan
- Reset: hold reset 3 cycles -> all outputs 0; cpu_ready rises 2 cycles after release.
- Single client, NUM_CLIENTS=2, req[1] asserted while cpu_sync=0 for 5 cycles then 1 -> grant=2'b10 next cycle, cpu_ready=0; client writes 8'hA5 to 11'h200, reads back, rvalid 1 cycle later with 8'hA5; req drop -> 1 RESTORE cycle with ram_addr=cpu_addr, then cpu_ready=1.
- Fixed priority: req=2'b11 at sync -> client 0 granted; after release client 1 granted only at next cpu_sync.
- Round robin, NUM_CLIENTS=3, all requesting continuously, sync every 4 cycles -> grant order 0,1,2,0.
- MAX_GRANT=4, client holds req 10 cycles -> grant exactly 4 cycles, RESTORE, CPU runs to next sync, client re-granted.
- Reset asserted during GRANT with client_we=1 -> grant and ram_we 0 the next cycle, RAM content unchanged afterwards.
